// File: rtl/req_ack_responder.sv
// Req/ack responder: acks each accepted req after ACK_LATENCY cycles and enforces MIN_REQ_GAP.
// Define ACK_STRETCH_EN to hold ack high for ACK_HOLD cycles instead of a single-cycle pulse.
module req_ack_responder #(
   parameter int unsigned ACK_LATENCY = 4,
   parameter int unsigned MIN_REQ_GAP = 8,
   parameter int unsigned ACK_HOLD    = 1,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic             clr_err,
   output logic             ack,
   output logic             busy,
   output logic             gap_err,
   output logic [CNT_W-1:0] req_cnt,
   output logic [CNT_W-1:0] ack_cnt
);

`ifdef ACK_STRETCH_EN
   localparam int unsigned HOLD = ACK_HOLD;
`else
   localparam int unsigned HOLD = 1;
`endif

   localparam int unsigned EW = $clog2(MIN_REQ_GAP + 1);
   // Values of elapsed in the last cycle of each phase.
   localparam logic [EW-1:0] WAIT_LAST = EW'(ACK_LATENCY - 1);
   localparam logic [EW-1:0] ACK_LAST  = EW'(ACK_LATENCY + HOLD - 1);
   localparam logic [EW-1:0] GAP_LAST  = EW'(MIN_REQ_GAP - 1);

   if (ACK_LATENCY < 1) begin : g_bad_latency
      $error("ACK_LATENCY must be >= 1");
   end
   if (ACK_HOLD < 1) begin : g_bad_hold
      $error("ACK_HOLD must be >= 1");
   end
   if (ACK_LATENCY + HOLD > MIN_REQ_GAP) begin : g_bad_gap
      $error("ACK_LATENCY + ack high time must not exceed MIN_REQ_GAP");
   end

   typedef enum logic [1:0] {StIdle, StWaitAck, StAck, StCooldown} state_t;

   state_t           r_state;
   state_t           w_state_d;
   logic [EW-1:0]    r_elapsed;
   logic [EW-1:0]    w_elapsed_d;
   logic             w_accept;
   logic             w_viol;
   logic             r_ack;
   logic             r_ack_dly;
   logic             r_gap_err;
   logic [CNT_W-1:0] r_req_cnt;
   logic [CNT_W-1:0] r_ack_cnt;

   always_comb begin
      w_state_d   = r_state;
      w_elapsed_d = r_elapsed;
      w_accept    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (req) begin
               w_accept    = 1'b1;
               w_elapsed_d = EW'(1);
               w_state_d   = (ACK_LATENCY == 1) ? StAck : StWaitAck;
            end
         end
         StWaitAck: begin
            w_elapsed_d = r_elapsed + EW'(1);
            if (r_elapsed == WAIT_LAST) w_state_d = StAck;
         end
         StAck: begin
            w_elapsed_d = r_elapsed + EW'(1);
            // Ack may end exactly at the gap boundary; skip cooldown then.
            if (r_elapsed == ACK_LAST) begin
               w_state_d = (r_elapsed == GAP_LAST) ? StIdle : StCooldown;
            end
         end
         StCooldown: begin
            w_elapsed_d = r_elapsed + EW'(1);
            if (r_elapsed == GAP_LAST) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
      w_viol = req && (r_state != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_elapsed <= '0;
         r_ack     <= 1'b0;
         r_ack_dly <= 1'b0;
         r_gap_err <= 1'b0;
         r_req_cnt <= '0;
         r_ack_cnt <= '0;
      end else begin
         r_state   <= w_state_d;
         r_elapsed <= w_elapsed_d;
         r_ack     <= (w_state_d == StAck);
         r_ack_dly <= r_ack;
         if (w_viol) begin
            r_gap_err <= 1'b1;
         end else if (clr_err) begin
            r_gap_err <= 1'b0;
         end
         if (w_accept) r_req_cnt <= r_req_cnt + CNT_W'(1);
         if (r_ack && !r_ack_dly) r_ack_cnt <= r_ack_cnt + CNT_W'(1);
      end
   end

   assign ack     = r_ack;
   assign busy    = (r_state != StIdle);
   assign gap_err = r_gap_err;
   assign req_cnt = r_req_cnt;
   assign ack_cnt = r_ack_cnt;

endmodule
